urv_irq_ctrl: RTL and testbench

Multi-source interrupt controller that feeds the single `exp_irq_i` line of the exception unit. It synchronises up to 32 external interrupt sources and latches each as edge- or level-type. It masks the sources, picks one by fixed priority, and serialises servicing through a claim/complete handshake on a small register port driven by the core's load/store path. Only one interrupt is in service at a time; there is no nesting.

---
 rtl/urv_irq_pkg.sv | 33 +++
 rtl/urv_irq_sync.sv | 44 ++++
 rtl/urv_irq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_urv_irq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_irq_pkg.sv
// Shared definitions for the urv interrupt controller.
// Register map, FSM encoding and the fixed-priority pick helper.
package urv_irq_pkg;

    localparam int ID_W            = 5;
    localparam int CLAIM_VALID_BIT = 31;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Returns {valid, id} of the lowest set bit.
    function automatic logic [ID_W:0] prio_pick(
        input logic [31:0] req
    );
        logic [ID_W:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                r = {1'b1, ID_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/urv_irq_sync.sv
// Single-bit source synchroniser with rising-edge detect.
// With SYNC_EN=0 the metastability stage is bypassed.
module urv_irq_sync #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    generate
        if (SYNC_EN) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta <= 1'b0;
                end else begin
                    meta <= src;
                end
            end
        end else begin : g_bypass
            assign meta = src;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/urv_irq_ctrl.sv
// Multi-source interrupt controller feeding the exception unit.
// Fixed-priority pick with a claim/complete register handshake.
module urv_irq_ctrl
    import urv_irq_pkg::*;
#(
    parameter int N_IRQ   = 8,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_IRQ-1:0] irq_src_i,
    input  logic             bus_sel_i,
    input  logic             bus_we_i,
    input  logic [3:0]       bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_ack_o,
    output logic             irq_o
);

    logic [N_IRQ-1:0] level;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] enable;
    logic [N_IRQ-1:0] edge_type;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] pending_nxt;

    logic [31:0] en_ext;
    logic [31:0] pend_ext;
    logic [31:0] edge_ext;
    logic [31:0] rdata_nxt;

    irq_state_e      state;
    irq_state_e      state_nxt;
    logic [ID_W-1:0] active_id;
    logic [ID_W-1:0] win_id;
    logic            win;

    logic [1:0] reg_sel;
    logic       rd;
    logic       wr;
    logic       rd_en;
    logic       rd_pend;
    logic       rd_edge;
    logic       rd_claim;
    logic       en_wr;
    logic       pend_wr;
    logic       edge_wr;
    logic       claim_go;
    logic       complete;

    logic unused;
    assign unused = ^{bus_addr_i[1:0], bus_wdata_i};

    genvar g;
    generate
        for (g = 0; g < N_IRQ; g++) begin : g_src
            urv_irq_sync #(
                .SYNC_EN(SYNC_EN)
            ) u_sync (
                .clk  (clk_i),
                .rst_n(rst_n_i),
                .src  (irq_src_i[g]),
                .level(level[g]),
                .rise (rise[g])
            );
        end
    endgenerate

    always_comb begin
        en_ext   = '0;
        pend_ext = '0;
        edge_ext = '0;
        en_ext[N_IRQ-1:0]   = enable;
        pend_ext[N_IRQ-1:0] = pending;
        edge_ext[N_IRQ-1:0] = edge_type;
    end

    assign {win, win_id} = prio_pick(en_ext & pend_ext);

    assign reg_sel  = bus_addr_i[3:2];
    assign rd       = bus_sel_i & ~bus_we_i;
    assign wr       = bus_sel_i & bus_we_i;
    assign rd_en    = rd && (reg_sel == REG_ENABLE);
    assign rd_pend  = rd && (reg_sel == REG_PENDING);
    assign rd_edge  = rd && (reg_sel == REG_EDGE);
    assign rd_claim = rd && (reg_sel == REG_CLAIM);
    assign en_wr    = wr && (reg_sel == REG_ENABLE);
    assign pend_wr  = wr && (reg_sel == REG_PENDING);
    assign edge_wr  = wr && (reg_sel == REG_EDGE);

    assign claim_go = rd_claim && win && (state != ST_SERVICE);
    assign complete = wr && (reg_sel == REG_CLAIM)
                   && (state == ST_SERVICE)
                   && (bus_wdata_i[ID_W-1:0] == active_id);

    // Edge bits: a fresh rise beats a same-cycle clear.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < N_IRQ; i++) begin
            if (edge_type[i]) begin
                if (pend_wr && bus_wdata_i[i]) begin
                    pending_nxt[i] = 1'b0;
                end
                if (claim_go && (win_id == ID_W'(i))) begin
                    pending_nxt[i] = 1'b0;
                end
                if (rise[i]) begin
                    pending_nxt[i] = 1'b1;
                end
            end else begin
                pending_nxt[i] = level[i];
            end
            if (edge_wr && !edge_type[i] && bus_wdata_i[i]) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (claim_go) begin
                    state_nxt = ST_SERVICE;
                end else if (win) begin
                    state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (claim_go) begin
                    state_nxt = ST_SERVICE;
                end else if (!win) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (complete) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_nxt = '0;
        unique case (1'b1)
            rd_en:   rdata_nxt = en_ext;
            rd_pend: rdata_nxt = pend_ext;
            rd_edge: rdata_nxt = edge_ext;
            rd_claim: begin
                if (state == ST_SERVICE) begin
                    rdata_nxt[CLAIM_VALID_BIT] = 1'b1;
                    rdata_nxt[ID_W-1:0]        = active_id;
                end else if (win) begin
                    rdata_nxt[CLAIM_VALID_BIT] = 1'b1;
                    rdata_nxt[ID_W-1:0]        = win_id;
                end
            end
            default: rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable      <= '0;
            edge_type   <= '0;
            pending     <= '0;
            state       <= ST_IDLE;
            active_id   <= '0;
            irq_o       <= 1'b0;
            bus_ack_o   <= 1'b0;
            bus_rdata_o <= '0;
        end else begin
            if (en_wr) begin
                enable <= bus_wdata_i[N_IRQ-1:0];
            end
            if (edge_wr) begin
                edge_type <= bus_wdata_i[N_IRQ-1:0];
            end
            if (claim_go) begin
                active_id <= win_id;
            end
            pending     <= pending_nxt;
            state       <= state_nxt;
            irq_o       <= (state_nxt == ST_ASSERT);
            bus_ack_o   <= bus_sel_i;
            bus_rdata_o <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Randomised bench for urv_irq_ctrl against a behavioural model,
// preceded by directed scenarios with hand-computed expectations.
module tb_urv_irq_ctrl;

    localparam int N = 8;
    localparam logic [31:0] MASK = 32'((64'd1 << N) - 1);
    localparam logic [31:0] VB = 32'h8000_0000;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  src;
    logic          bus_sel;
    logic          bus_we;
    logic [3:0]    bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_ack;
    logic          irq;

    int total = 0;
    int bad   = 0;

    urv_irq_ctrl #(
        .N_IRQ  (N),
        .SYNC_EN(1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .irq_src_i  (src),
        .bus_sel_i  (bus_sel),
        .bus_we_i   (bus_we),
        .bus_addr_i (bus_addr),
        .bus_wdata_i(bus_wdata),
        .bus_rdata_o(bus_rdata),
        .bus_ack_o  (bus_ack),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural model: sources are seen through a two-edge delay line.
    logic [31:0] m_en, m_ed, m_pend, m_rdata;
    logic [31:0] h0, h1, h2, m_lvl, m_rise, np;
    logic        m_srv, m_irq, m_ack;
    int          m_active, m_w;
    bit          m_rd, m_wr, m_claim, m_done;
    logic [1:0]  ra;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en = '0; m_ed = '0; m_pend = '0; m_rdata = '0;
            h0 = '0; h1 = '0; h2 = '0;
            m_srv = 1'b0; m_irq = 1'b0; m_ack = 1'b0;
            m_active = 0;
        end else begin
            m_w = lowest(m_en & m_pend);
            m_lvl = h1;
            m_rise = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = 32'(src);
            m_rd = bus_sel && !bus_we;
            m_wr = bus_sel && bus_we;
            ra = bus_addr[3:2];
            m_rdata = '0;
            if (m_rd) begin
                case (ra)
                    2'd0: m_rdata = m_en;
                    2'd1: m_rdata = m_pend;
                    2'd2: m_rdata = m_ed;
                    default: begin
                        if (m_srv) m_rdata = VB | 32'(m_active);
                        else if (m_w >= 0) m_rdata = VB | 32'(m_w);
                    end
                endcase
            end
            m_claim = m_rd && ra == 2'd3 && !m_srv && m_w >= 0;
            m_done = m_wr && ra == 2'd3 && m_srv
                  && bus_wdata[4:0] == 5'(m_active);
            np = '0;
            for (int i = 0; i < N; i++) begin
                if (m_ed[i]) begin
                    np[i] = m_pend[i];
                    if (m_wr && ra == 2'd1 && bus_wdata[i]) np[i] = 1'b0;
                    if (m_claim && m_w == i) np[i] = 1'b0;
                    if (m_rise[i]) np[i] = 1'b1;
                end else begin
                    np[i] = m_lvl[i];
                end
                if (m_wr && ra == 2'd2 && !m_ed[i] && bus_wdata[i])
                    np[i] = 1'b0;
            end
            m_irq = !m_srv && m_w >= 0 && !m_claim;
            if (m_wr && ra == 2'd0) m_en = bus_wdata & MASK;
            if (m_wr && ra == 2'd2) m_ed = bus_wdata & MASK;
            m_pend = np;
            if (m_claim) begin
                m_srv = 1'b1;
                m_active = m_w;
            end else if (m_done) begin
                m_srv = 1'b0;
            end
            m_ack = bus_sel;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("irq_o", 32'(irq), 32'(m_irq));
            check("bus_ack_o", 32'(bus_ack), 32'(m_ack));
            check("bus_rdata_o", bus_rdata, m_rdata);
        end
    end

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_sel = 1'b0;
        d = bus_rdata;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] d;
    int hold[N];
    int r;

    initial begin
        rst_n = 1'b0; src = '0;
        bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset irq", 32'(irq), 32'd0);
        check("reset ack", 32'(bus_ack), 32'd0);
        check("reset rdata", bus_rdata, 32'd0);
        rst_n = 1'b1;

        // Edge claim/complete
        bus_wr(4'h8, 32'h01);
        bus_wr(4'h0, 32'h01);
        @(negedge clk); src[0] = 1'b1;
        wait_cyc(2);
        src[0] = 1'b0;
        wait_cyc(1);
        check("edge irq before", 32'(irq), 32'd0);
        wait_cyc(1);
        check("edge irq k+3", 32'(irq), 32'd1);
        bus_rd(4'hC, d);
        check("edge claim", d, 32'h8000_0000);
        check("edge irq drop", 32'(irq), 32'd0);
        bus_rd(4'h4, d);
        check("edge pend clr", d, 32'h0);
        bus_wr(4'hC, 32'h0);
        bus_rd(4'hC, d);
        check("edge idle claim", d, 32'h0);

        // Priority
        bus_wr(4'h8, 32'h00);
        bus_wr(4'h0, 32'hFF);
        src[5] = 1'b1; src[2] = 1'b1;
        wait_cyc(5);
        bus_rd(4'hC, d);
        check("prio claim 2", d, 32'h8000_0002);
        bus_wr(4'hC, 32'h2);
        wait_cyc(2);
        check("prio reassert", 32'(irq), 32'd1);
        bus_rd(4'hC, d);
        check("prio claim 2b", d, 32'h8000_0002);
        bus_wr(4'hC, 32'h2);
        src[2] = 1'b0;
        wait_cyc(4);
        bus_rd(4'hC, d);
        check("prio claim 5", d, 32'h8000_0005);
        bus_wr(4'hC, 32'h5);
        src[5] = 1'b0;
        wait_cyc(4);

        // Masking
        bus_wr(4'h0, 32'h00);
        src[3] = 1'b1;
        wait_cyc(5);
        check("mask irq", 32'(irq), 32'd0);
        bus_rd(4'h4, d);
        check("mask pend", d, 32'h08);
        bus_wr(4'h0, 32'h08);
        wait_cyc(1);
        check("unmask irq", 32'(irq), 32'd1);

        // Wrong complete
        src[3] = 1'b0; src[4] = 1'b1;
        bus_wr(4'h0, 32'h10);
        wait_cyc(5);
        bus_rd(4'hC, d);
        check("svc claim 4", d, 32'h8000_0004);
        bus_wr(4'hC, 32'h1);
        check("svc irq", 32'(irq), 32'd0);
        bus_rd(4'hC, d);
        check("svc stay 4", d, 32'h8000_0004);
        bus_wr(4'hC, 32'h4);
        src[4] = 1'b0;
        wait_cyc(4);

        // Set vs W1C collision
        bus_wr(4'h0, 32'h00);
        bus_wr(4'h8, 32'h02);
        @(negedge clk); src[1] = 1'b1;
        @(negedge clk);
        bus_wr(4'h4, 32'h02);
        bus_rd(4'h4, d);
        check("set wins", d, 32'h02);
        bus_wr(4'h4, 32'h02);
        bus_rd(4'h4, d);
        check("w1c clears", d, 32'h00);

        // Async reset in ASSERT
        src[1] = 1'b0;
        wait_cyc(3);
        src[1] = 1'b1;
        wait_cyc(4);
        bus_wr(4'h0, 32'h02);
        wait_cyc(1);
        src = '0;
        check("pre-reset irq", 32'(irq), 32'd1);
        bus_rd(4'h0, d);
        check("pre-reset ack", 32'(bus_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async irq", 32'(irq), 32'd0);
        check("async ack", 32'(bus_ack), 32'd0);
        check("async rdata", bus_rdata, 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_rd(4'(a * 4), d);
            check("post-reset reg", d, 32'h0);
        end

        // Random traffic
        for (int b = 0; b < N; b++) hold[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if (hold[b] >= 2 && $urandom_range(0, 7) == 0) begin
                    src[b] = ~src[b];
                    hold[b] = 0;
                end else begin
                    hold[b]++;
                end
            end
            r = $urandom_range(0, 99);
            bus_sel = (r < 45);
            bus_we = 1'($urandom_range(0, 1));
            bus_addr = 4'($urandom);
            bus_wdata = $urandom;
            if (m_srv && $urandom_range(0, 3) == 0) begin
                bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 4'hC;
                bus_wdata = {27'b0, 5'(m_active)};
            end else if (irq && $urandom_range(0, 2) == 0) begin
                bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 4'hC;
            end
        end
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0;
        wait_cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
